// File: rtl/rom_pkg.sv
// Shared constants for the LEGv8 instruction ROM: default widths, opcode fields,
// small instruction encoders and the built-in GPIO/timer test program image.
package rom_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 16;

    // BR XZR: parks the core on an unprogrammed or out-of-range fetch.
    localparam logic [31:0] BR_XZR_WORD = 32'hD60003E0;

    // LEGv8 opcode fields (MOVZ is the 9-bit IW-format opcode).
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;

    localparam logic [4:0] REG_XZR = 5'd31;

    // Number of leading words defined by the image; the rest are BR XZR.
    localparam int unsigned ROM_IMAGE_LEN = 8;

    // IW format: opcode, hw, imm16, Rd.
    function automatic logic [31:0] enc_movz(logic [4:0] rd, logic [15:0] imm, logic [1:0] hw);
        return {OP_MOVZ, hw, imm, rd};
    endfunction

    // R format: opcode, Rm, shamt, Rn, Rd.
    function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm, logic [5:0] shamt,
                                          logic [4:0] rn, logic [4:0] rd);
        return {op, rm, shamt, rn, rd};
    endfunction

    // D format: opcode, DT address, op2, Rn, Rt.
    function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] dt_addr, logic [4:0] rn,
                                          logic [4:0] rt);
        return {op, dt_addr, 2'b00, rn, rt};
    endfunction

    // GPIO/timer test program, indexed by word address.
    function automatic logic [31:0] ROM_IMAGE(int unsigned idx);
        logic [31:0] word;
        case (idx)
            0:       word = enc_movz(5'd1, 16'd5, 2'd0);                  // MOVZ X1, #5
            1:       word = enc_r(OP_LSL, 5'd0, 6'd56, 5'd1, 5'd1);       // LSL X1, X1, #56
            2:       word = enc_d(OP_LDUR, 9'd4, 5'd1, 5'd10);            // LDUR X10, [X1, #4]
            3:       word = enc_d(OP_STUR, 9'd3, 5'd1, 5'd10);            // STUR X10, [X1, #3]
            4:       word = enc_r(OP_BR, 5'd0, 6'd0, REG_XZR, 5'd0);      // BR XZR
            5:       word = enc_movz(5'd2, 16'h0010, 2'd0);               // MOVZ X2, #16
            6:       word = enc_d(OP_STUR, 9'd8, 5'd1, 5'd2);             // STUR X2, [X1, #8]
            7:       word = enc_r(OP_BR, 5'd0, 6'd0, REG_XZR, 5'd0);      // BR XZR
            default: word = BR_XZR_WORD;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/rom_rsp_fifo.sv
// In-order synchronous response queue. Push and pop may happen at the same
// edge; the caller must not push while full. Pops on an empty queue are ignored.
module rom_rsp_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] store_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CntW'(Depth));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = store_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    // Next pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_rom_fetch.sv
// Synchronous instruction ROM with a valid/ready fetch channel, one-cycle read
// latency, an in-order response queue for backpressure and a run-time loader port.
module instr_rom_fetch
    import rom_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned           DEPTH        = 64,
    parameter int unsigned           FIFO_DEPTH   = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(BR_XZR_WORD)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_oob,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_err
);

    localparam int unsigned MEM_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    // DEPTH widened by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    if (FIFO_DEPTH < 1) begin : gen_bad_fifo_depth
        $error("instr_rom_fetch: FIFO_DEPTH must be at least 1");
    end
    if (ADDR_WIDTH < 31) begin : gen_depth_check
        if (DEPTH > (32'd1 << ADDR_WIDTH)) begin : gen_bad_depth
            $error("instr_rom_fetch: DEPTH exceeds the address space");
        end
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  req_oob, load_oob;
    logic [DATA_WIDTH-1:0] read_word;
    logic                  req_fire, rsp_fire;
    logic                  load_err_q;
    logic [DATA_WIDTH:0]   head;
    logic [DATA_WIDTH:0]   last_q;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full, fifo_empty;

    // Full-width range checks: no aliasing of high addresses onto the array.
    assign req_oob  = ({1'b0, req_addr} >= DEPTH_EXT);
    assign load_oob = ({1'b0, load_addr} >= DEPTH_EXT);

    // Reads see the array before any same-edge load lands, giving old-word semantics.
    assign read_word = req_oob ? DEFAULT_WORD : mem_q[req_addr[MEM_IDX_W-1:0]];

    // Readiness comes only from the registered occupancy.
    assign req_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign req_fire  = req_valid && req_ready && !reset;
    assign rsp_valid = !fifo_empty;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign load_err  = load_err_q;

    // Instruction array: image reload on reset, otherwise in-range loader writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < ROM_IMAGE_LEN) ? DATA_WIDTH'(ROM_IMAGE(i)) : DEFAULT_WORD;
            end
        end else if (load_en && !load_oob) begin
            mem_q[load_addr[MEM_IDX_W-1:0]] <= load_data;
        end
    end

    // One-cycle error pulse for loader writes that fall outside the array.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_en && load_oob;
        end
    end

    rom_rsp_fifo #(
        .Width (DATA_WIDTH + 1),
        .Depth (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (req_fire),
        .push_data_i ({req_oob, read_word}),
        .pop_i       (rsp_fire),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Remember the last presented head so outputs hold once the queue empties.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= '0;
        end else if (rsp_valid) begin
            last_q <= head;
        end
    end

    // Present the queue head while valid, otherwise the held value.
    always_comb begin
        rsp_oob  = last_q[DATA_WIDTH];
        rsp_data = last_q[DATA_WIDTH-1:0];
        if (rsp_valid) begin
            rsp_oob  = head[DATA_WIDTH];
            rsp_data = head[DATA_WIDTH-1:0];
        end
    end

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_rom_fetch.sv
// Scoreboard bench for instr_rom_fetch: stimulus pushes expectations computed
// from a behavioural memory model; a negedge monitor pops and compares.
module tb_instr_rom_fetch;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int DEPTH = 64;
    localparam int FD = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_oob;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          load_err;

    instr_rom_fetch #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .FIFO_DEPTH   (FD),
        .DEFAULT_WORD (32'hD60003E0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_oob   (rsp_oob),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_err  (load_err)
    );

    always #5 clock = ~clock;

    // Reference program image, written out as plain instruction words.
    function automatic logic [31:0] image_word(int i);
        case (i)
            0: return 32'hD28000A1;
            1: return 32'hD360E021;
            2: return 32'hF840402A;
            3: return 32'hF800302A;
            5: return 32'hD2800202;
            6: return 32'hF8008022;
            default: return 32'hD60003E0;
        endcase
    endfunction

    typedef struct {
        logic        oob;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic [31:0] model_mem [DEPTH];
    exp_t        exp_q [$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops = 0;
    int          pushes = 0;
    int          cleared = 0;
    bit          strict_lat = 0;
    bit          stall_prev = 0;
    logic [32:0] stall_val = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    // Monitor/model: sees the inputs that the coming posedge will act on.
    always @(negedge clock) begin
        if (reset) begin
            cleared += exp_q.size();
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) model_mem[i] = image_word(i);
            stall_prev = 0;
        end else begin
            chk("req_ready", {63'd0, req_ready}, {63'd0, exp_q.size() < FD});
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_q.size() > 0});
            if (stall_prev) begin
                chk("stall_hold", {31'd0, rsp_oob, rsp_data}, {31'd0, stall_val});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got %h with nothing outstanding", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    chk("rsp", {31'd0, rsp_oob, rsp_data}, {31'd0, e.oob, e.data});
                    if (strict_lat) chk("latency", 64'(cyc - e.cyc), 64'd1);
                end
            end
            stall_prev = rsp_valid && !rsp_ready;
            stall_val  = {rsp_oob, rsp_data};
            if (req_valid && req_ready) begin
                e.oob  = (req_addr >= DEPTH);
                e.data = e.oob ? 32'hD60003E0 : model_mem[req_addr];
                e.cyc  = cyc;
                exp_q.push_back(e);
                pushes++;
            end
            if (load_en && load_addr < DEPTH) model_mem[load_addr] = load_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request and hold it until the handshake edge has passed.
    task automatic send(logic [AW-1:0] addr);
        bit acc;
        acc = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clock);
            acc = req_ready;
            tick();
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got req_ready=0, required 1 within 50 cycles");
        end
    endtask

    int pops_mark;

    initial begin
        // Reset state.
        tick();
        tick();
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("rst_rsp_oob", {63'd0, rsp_oob}, 64'd0);
        chk("rst_load_err", {63'd0, load_err}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        reset = 1'b0;

        // Back-to-back reads of 0..4 with one-cycle latency, then out-of-range.
        rsp_ready  = 1'b1;
        strict_lat = 1;
        for (int a = 0; a < 5; a++) send(AW'(a));
        send(16'h0064);
        req_valid = 1'b0;
        chk("oob_data", {32'd0, rsp_data}, 64'hD60003E0);
        chk("oob_flag", {63'd0, rsp_oob}, 64'd1);
        tick();
        tick();
        strict_lat = 0;

        // Backpressure: third request must stall while the queue is full.
        rsp_ready = 1'b0;
        pops_mark = pops;
        send(16'd0);
        send(16'd1);
        req_valid = 1'b1;
        req_addr  = 16'd2;
        for (int k = 0; k < 3; k++) begin
            chk("full_ready", {63'd0, req_ready}, 64'd0);
            chk("stall_data", {32'd0, rsp_data}, 64'hD28000A1);
            tick();
        end
        rsp_ready = 1'b1;
        send(16'd2);
        req_valid = 1'b0;
        repeat (3) tick();
        chk("bp_delivered", 64'(pops - pops_mark), 64'd3);

        // Same-edge load and read of address 3.
        load_en   = 1'b1;
        load_addr = 16'd3;
        load_data = 32'h12345678;
        send(16'd3);
        load_en = 1'b0;
        chk("collision_old", {32'd0, rsp_data}, 64'hF800302A);
        send(16'd3);
        chk("collision_new", {32'd0, rsp_data}, 64'h12345678);
        req_valid = 1'b0;
        tick();

        // Out-of-range load: one-cycle error pulse, no aliased write.
        load_en   = 1'b1;
        load_addr = 16'd64;
        load_data = 32'hDEADBEEF;
        tick();
        load_en = 1'b0;
        chk("load_err_pulse", {63'd0, load_err}, 64'd1);
        tick();
        chk("load_err_clear", {63'd0, load_err}, 64'd0);
        send(16'd0);
        chk("no_alias", {32'd0, rsp_data}, 64'hD28000A1);
        send(16'd3);
        chk("kept_load", {32'd0, rsp_data}, 64'h12345678);
        send(16'h8000);
        chk("high_oob", {63'd0, rsp_oob}, 64'd1);
        req_valid = 1'b0;
        tick();
        tick();

        // Reset with a full queue and a patched word; same-cycle inputs discarded.
        rsp_ready = 1'b0;
        send(16'd1);
        send(16'd2);
        req_valid = 1'b0;
        load_en   = 1'b1;
        load_addr = 16'd0;
        load_data = 32'hAAAA5555;
        tick();
        reset     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 16'd5;
        load_addr = 16'd1;
        load_data = 32'h0BADF00D;
        tick();
        reset     = 1'b0;
        req_valid = 1'b0;
        load_en   = 1'b0;
        chk("rst2_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst2_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst2_rsp_data", {32'd0, rsp_data}, 64'd0);
        rsp_ready = 1'b1;
        send(16'd0);
        chk("image_restored", {32'd0, rsp_data}, 64'hD28000A1);
        send(16'd1);
        chk("rst_load_dropped", {32'd0, rsp_data}, 64'hD360E021);
        req_valid = 1'b0;
        tick();

        // Random traffic against the model.
        for (int k = 0; k < 1000; k++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 70));
            rsp_ready = ($urandom_range(0, 3) != 0);
            load_en   = ($urandom_range(0, 15) == 0);
            load_addr = AW'($urandom_range(0, 70));
            load_data = $urandom;
            tick();
        end
        req_valid = 1'b0;
        load_en   = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        chk("drain_empty", {63'd0, rsp_valid}, 64'd0);
        chk("accounting", 64'(pops + cleared), 64'(pushes));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
